// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port RAM between instruction fetch and data access.
// Data wins arbitration unless a fetch has waited through STARVE_MAX data grants.
//   state | meaning
//   IDLE  | waiting for a request; grant and latch operands here
//   IACC  | instruction read in progress, wcount counts down RAM wait cycles
//   DACC  | data read or write in progress, wcount counts down RAM wait cycles
//   RESP  | one-cycle hit pulse to the owner, RAM strobes low
module mem_arbiter #(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IACC = 2'd1;
    localparam logic [1:0] DACC = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [3:0] LAT_W   = 4'(LAT);
    localparam logic [3:0] SMAX_W  = 4'(STARVE_MAX);

    logic [1:0]  state_q,  state_d;
    logic [3:0]  wcount_q, wcount_d;
    logic [3:0]  scount_q, scount_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] store_q,  store_d;
    logic        op_wr_q,  op_wr_d;
    logic        owner_q,  owner_d;   // 1 = data requester owns the access
    logic [31:0] iload_q,  iload_d;
    logic [31:0] dload_q,  dload_d;

    logic dreq;
    logic starve;

    assign dreq   = dREN | dWEN;
    assign starve = iREN && (scount_q == SMAX_W);

    always_comb begin
        state_d  = state_q;
        wcount_d = wcount_q;
        scount_d = scount_q;
        addr_d   = addr_q;
        store_d  = store_q;
        op_wr_d  = op_wr_q;
        owner_d  = owner_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        case (state_q)
            IDLE: begin
                if (dreq && !starve) begin
                    state_d  = DACC;
                    addr_d   = daddr;
                    store_d  = dstore;
                    op_wr_d  = dWEN;
                    owner_d  = 1'b1;
                    wcount_d = LAT_W;
                    if (iREN) begin
                        scount_d = (scount_q == SMAX_W) ? scount_q : scount_q + 4'd1;
                    end else begin
                        scount_d = 4'd0;
                    end
                end else if (iREN) begin
                    state_d  = IACC;
                    addr_d   = iaddr;
                    store_d  = dstore;
                    op_wr_d  = 1'b0;
                    owner_d  = 1'b0;
                    wcount_d = LAT_W;
                    scount_d = 4'd0;
                end
            end
            IACC: begin
                if (wcount_q == 4'd0) begin
                    iload_d = ramload;
                    state_d = RESP;
                end else begin
                    wcount_d = wcount_q - 4'd1;
                end
            end
            DACC: begin
                if (wcount_q == 4'd0) begin
                    if (!op_wr_q) begin
                        dload_d = ramload;
                    end
                    state_d = RESP;
                end else begin
                    wcount_d = wcount_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            wcount_q <= 4'd0;
            scount_q <= 4'd0;
            addr_q   <= 32'd0;
            store_q  <= 32'd0;
            op_wr_q  <= 1'b0;
            owner_q  <= 1'b0;
            iload_q  <= 32'd0;
            dload_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            wcount_q <= wcount_d;
            scount_q <= scount_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            op_wr_q  <= op_wr_d;
            owner_q  <= owner_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
        end
    end

    // Strobes and buses are pure state decodes so they stay stable for the whole access.
    assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !op_wr_q);
    assign ramWEN   = (state_q == DACC) && op_wr_q;
    assign ramaddr  = ((state_q == IACC) || (state_q == DACC)) ? addr_q : 32'd0;
    assign ramstore = (state_q == DACC) ? store_q : 32'd0;
    assign ihit     = (state_q == RESP) && !owner_q;
    assign dhit     = (state_q == RESP) && owner_q;
    assign busy     = (state_q != IDLE);
    assign iload    = iload_q;
    assign dload    = dload_q;

endmodule
